// File: rtl/opseq_pkg.sv
// Shared constants for the operand sequencer: mode encodings, table words, LFSR seed/taps.
// The LFSR values are only used when OPSEQ_LFSR_EN is defined.
package opseq_pkg;

  typedef enum logic [1:0] {
    MODE_MANUAL = 2'b00,
    MODE_STEP   = 2'b01,
    MODE_AUTO   = 2'b10,
    MODE_HOLD   = 2'b11
  } mode_e;

  localparam logic [63:0] TBL_B1    = 64'h0000_0000_0000_0607;
  localparam logic [31:0] TBL_A7    = 32'h1234_5678;
  localparam logic [31:0] TBL_B7    = 32'h3333_2222;
  localparam logic [31:0] LFSR_SEED = 32'hACE1_2345;

  // Replicate a 32-bit word from the LSB; callers truncate to their width.
  function automatic logic [63:0] rep64(input logic [31:0] v);
    return {v, v};
  endfunction

  // Galois (right-shift) tap masks; odd widths fall back to a top+bottom mask.
  function automatic logic [63:0] lfsr_taps(input int unsigned w);
    case (w)
      16:      return 64'h0000_0000_0000_B400;
      24:      return 64'h0000_0000_00E1_0000;
      32:      return 64'h0000_0000_8020_0003;
      48:      return 64'h0000_B400_0000_0000;
      64:      return 64'hD800_0000_0000_0000;
      default: return (64'd1 << (w - 1)) | 64'd1;
    endcase
  endfunction

endpackage

// File: rtl/opseq_table.sv
// Combinational 8-entry operand ROM, indexed by idx, parametrised on WIDTH.
module opseq_table
  import opseq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       idx,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b
);

  localparam logic [WIDTH-1:0] MIN_V  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] MAX_V  = ~MIN_V;
  localparam logic [WIDTH-1:0] ONES_V = '1;

  always_comb begin
    a = '0;
    b = '0;
    case (idx)
      3'd0: begin a = '0;           b = '0;                   end
      3'd1: begin a = WIDTH'(3);    b = WIDTH'(TBL_B1);       end
      3'd2: begin a = MIN_V;        b = MIN_V;                end
      3'd3: begin a = MAX_V;        b = MAX_V;                end
      3'd4: begin a = ONES_V;       b = ONES_V;               end
      3'd5: begin a = MIN_V;        b = ONES_V;               end
      3'd6: begin a = ONES_V;       b = MIN_V;                end
      3'd7: begin a = WIDTH'(rep64(TBL_A7)); b = WIDTH'(rep64(TBL_B7)); end
      default: begin a = '0;        b = '0;                   end
    endcase
  end

endmodule

// File: rtl/operand_sequencer.sv
// Presents (A,B) operand pairs from a fixed table under MANUAL/STEP/AUTO/HOLD control with a
// valid/ready handshake. Define OPSEQ_LFSR_EN to turn mode 11 into RANDOM (LFSR-driven operands).
module operand_sequencer
  import opseq_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int PERIOD = 25_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       mode,
  input  logic [2:0]       sel,
  input  logic             step,
  input  logic             out_ready,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic [2:0]       idx,
  output logic             out_valid,
  output logic             wrap
);

  localparam int unsigned   TW    = (PERIOD > 2) ? $clog2(PERIOD) : 1;
  localparam logic [TW-1:0] TLAST = TW'(PERIOD - 1);

  mode_e            mode_in, mode_q;
  logic [TW-1:0]    timer_q, timer_d;
  logic             pending_q, pending_d;
  logic             step_q, step_rise;
  logic             blocked, mode_change, timed, rnd;
  logic             load, advance;
  logic [2:0]       load_idx, idx_d;
  logic [WIDTH-1:0] tbl_a, tbl_b, a_d, b_d;
  logic             valid_d, wrap_d;

  assign mode_in     = mode_e'(mode);
  assign step_rise   = step & ~step_q;
  assign blocked     = out_valid & ~out_ready;
  assign mode_change = mode_in != mode_q;
  assign load_idx    = (mode_in == MODE_MANUAL) ? sel : idx + 3'd1;

`ifdef OPSEQ_LFSR_EN
  localparam logic [WIDTH-1:0] TAPS = WIDTH'(lfsr_taps(WIDTH));
  localparam logic [WIDTH-1:0] SEED = WIDTH'(rep64(LFSR_SEED));
  localparam int unsigned      HALF = WIDTH / 2;
  logic [WIDTH-1:0] lfsr_q, lfsr_d;
  assign rnd = mode_in == MODE_HOLD;
`else
  assign rnd = 1'b0;
`endif
  assign timed = (mode_in == MODE_AUTO) | rnd;

  opseq_table #(.WIDTH(WIDTH)) u_table (
    .idx (load_idx),
    .a   (tbl_a),
    .b   (tbl_b)
  );

  always_comb begin
    idx_d     = idx;
    a_d       = A;
    b_d       = B;
    valid_d   = out_valid;
    wrap_d    = 1'b0;
    timer_d   = timer_q;
    pending_d = pending_q;
    load      = 1'b0;
    advance   = 1'b0;
`ifdef OPSEQ_LFSR_EN
    lfsr_d    = lfsr_q;
`endif
    // A mode change only resets the timer/pending state; the new mode acts from the next cycle.
    if (mode_change) begin
      timer_d   = '0;
      pending_d = 1'b0;
    end else begin
      if (!timed) begin
        timer_d = '0;
      end else if (!blocked) begin
        if (timer_q == TLAST) begin
          timer_d = '0;
          load    = 1'b1;
          advance = 1'b1;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      if (mode_in != MODE_STEP) begin
        pending_d = 1'b0;
      end else if (blocked) begin
        if (step_rise) pending_d = 1'b1;
      end else begin
        pending_d = 1'b0;
        if (step_rise || pending_q) begin
          load    = 1'b1;
          advance = 1'b1;
        end
      end
      if (mode_in == MODE_MANUAL && !blocked && sel != idx) load = 1'b1;
    end

`ifdef OPSEQ_LFSR_EN
    if (load && rnd) begin
      valid_d = 1'b1;
      idx_d   = 3'd7;
      a_d     = lfsr_q;
      b_d     = (lfsr_q << HALF) | (lfsr_q >> (WIDTH - HALF));
      lfsr_d  = lfsr_q[0] ? ((lfsr_q >> 1) ^ TAPS) : (lfsr_q >> 1);
    end else
`endif
    if (load) begin
      valid_d = 1'b1;
      idx_d   = load_idx;
      a_d     = tbl_a;
      b_d     = tbl_b;
      wrap_d  = advance && (idx == 3'd7);
    end else if (out_valid && out_ready) begin
      valid_d = 1'b0;
    end
  end

  // Tracks mode even during reset so a mode held across reset is not seen as a change.
  always_ff @(posedge clk) begin
    mode_q <= mode_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx       <= '0;
      A         <= '0;
      B         <= '0;
      out_valid <= 1'b0;
      wrap      <= 1'b0;
      timer_q   <= '0;
      pending_q <= 1'b0;
      step_q    <= 1'b0;
`ifdef OPSEQ_LFSR_EN
      lfsr_q    <= SEED;
`endif
    end else begin
      idx       <= idx_d;
      A         <= a_d;
      B         <= b_d;
      out_valid <= valid_d;
      wrap      <= wrap_d;
      timer_q   <= timer_d;
      pending_q <= pending_d;
      step_q    <= step;
`ifdef OPSEQ_LFSR_EN
      lfsr_q    <= lfsr_d;
`endif
    end
  end

endmodule

// File: tb/tb_operand_sequencer.sv
// Directed + randomized bench for operand_sequencer (WIDTH=32, PERIOD=4) against a behavioural model.
// Build with OPSEQ_LFSR_EN defined to exercise the RANDOM mode instead of HOLD.
module tb_operand_sequencer;
  import opseq_pkg::*;

  localparam int W = 32;
  localparam int P = 4;
`ifdef OPSEQ_LFSR_EN
  localparam bit LFSR_ON = 1'b1;
`else
  localparam bit LFSR_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    mode;
  logic [2:0]    sel;
  logic          step;
  logic          out_ready;
  logic [W-1:0]  A, B;
  logic [2:0]    idx;
  logic          out_valid, wrap;

  operand_sequencer #(.WIDTH(W), .PERIOD(P)) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .sel       (sel),
    .step      (step),
    .out_ready (out_ready),
    .A         (A),
    .B         (B),
    .idx       (idx),
    .out_valid (out_valid),
    .wrap      (wrap)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [2:0]  m_idx;
  logic [31:0] m_a, m_b, m_lfsr;
  bit          m_valid, m_wrap, m_pending, m_step;
  int          m_timer;
  logic [1:0]  m_mode;

  function automatic logic [31:0] ref_a(input logic [2:0] i);
    logic [31:0] mn, ones;
    mn   = 32'd1 << (W - 1);
    ones = ~32'd0;
    case (i)
      3'd0: return 32'd0;
      3'd1: return 32'd3;
      3'd2: return mn;
      3'd3: return mn - 32'd1;
      3'd4: return ones;
      3'd5: return mn;
      3'd6: return ones;
      default: return 32'h1234_5678;
    endcase
  endfunction

  function automatic logic [31:0] ref_b(input logic [2:0] i);
    logic [31:0] mn, ones;
    mn   = 32'd1 << (W - 1);
    ones = ~32'd0;
    case (i)
      3'd0: return 32'd0;
      3'd1: return 32'h607;
      3'd2: return mn;
      3'd3: return mn - 32'd1;
      3'd4: return ones;
      3'd5: return ones;
      3'd6: return mn;
      default: return 32'h3333_2222;
    endcase
  endfunction

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    logic [63:0] t;
    t = lfsr_taps(32);
    return s[0] ? ((s >> 1) ^ t[31:0]) : (s >> 1);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Applies the behavioural rules to the model for the inputs about to be sampled.
  task automatic model_edge();
    bit blk, ld, adv, rise;
    logic [2:0] tgt;
    if (rst) begin
      m_idx = 0; m_a = 0; m_b = 0; m_valid = 0; m_wrap = 0;
      m_timer = 0; m_pending = 0; m_step = 0; m_lfsr = 32'hACE1_2345;
      m_mode = mode;
      return;
    end
    blk  = m_valid && !out_ready;
    rise = step && !m_step;
    ld = 0; adv = 0; tgt = m_idx;
    if (mode != m_mode) begin
      m_timer = 0; m_pending = 0;
    end else begin
      case (mode)
        2'b00: begin
          m_timer = 0; m_pending = 0;
          if (!blk && sel != m_idx) begin ld = 1; tgt = sel; end
        end
        2'b01: begin
          m_timer = 0;
          if (blk) m_pending = m_pending | rise;
          else if (rise || m_pending) begin ld = 1; adv = 1; m_pending = 0; end
        end
        default: begin
          m_pending = 0;
          if (mode == 2'b10 || LFSR_ON) begin
            if (!blk) begin
              if (m_timer == P - 1) begin m_timer = 0; ld = 1; adv = 1; end
              else m_timer++;
            end
          end else m_timer = 0;
        end
      endcase
    end
    m_wrap = 0;
    if (ld && mode == 2'b11) begin
      m_idx = 3'd7; m_a = m_lfsr; m_b = {m_lfsr[15:0], m_lfsr[31:16]};
      m_lfsr = lfsr_next(m_lfsr); m_valid = 1;
    end else if (ld) begin
      m_wrap = adv && (m_idx == 3'd7);
      if (adv) tgt = m_idx + 3'd1;
      m_idx = tgt; m_a = ref_a(tgt); m_b = ref_b(tgt); m_valid = 1;
    end else if (m_valid && out_ready) begin
      m_valid = 0;
    end
    m_step = step;
    m_mode = mode;
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    chk("m_idx",   64'(idx),       64'(m_idx));
    chk("m_A",     64'(A),         64'(m_a));
    chk("m_B",     64'(B),         64'(m_b));
    chk("m_valid", 64'(out_valid), 64'(m_valid));
    chk("m_wrap",  64'(wrap),      64'(m_wrap));
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic until_change(input int limit, output int n);
    logic [2:0] prev;
    prev = idx;
    n = limit + 1;
    for (int i = 1; i <= limit; i++) begin
      tick();
      if (idx != prev) begin n = i; break; end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit found;
    rst = 1; mode = 2'b00; sel = 0; step = 0; out_ready = 0;
    ticks(2);
    chk("rst_idx", 64'(idx), 0);
    chk("rst_A", 64'(A), 0);
    chk("rst_B", 64'(B), 0);
    chk("rst_valid", 64'(out_valid), 0);
    chk("rst_wrap", 64'(wrap), 0);

    rst = 0;
    tick();
    chk("first_no_load", 64'(out_valid), 0);

    sel = 5;
    tick();
    chk("man5_A", 64'(A), 64'h8000_0000);
    chk("man5_B", 64'(B), 64'hFFFF_FFFF);
    chk("man5_idx", 64'(idx), 5);
    chk("man5_valid", 64'(out_valid), 1);
    sel = 2;
    ticks(3);
    chk("blocked_idx", 64'(idx), 5);
    chk("blocked_A", 64'(A), 64'h8000_0000);
    out_ready = 1;
    tick();
    chk("man2_idx", 64'(idx), 2);
    chk("man2_B", 64'(B), 64'h8000_0000);
    chk("man2_valid", 64'(out_valid), 1);
    sel = 0;
    tick();
    chk("man0_idx", 64'(idx), 0);
    chk("man0_nowrap", 64'(wrap), 0);
    tick();
    chk("hs_clear", 64'(out_valid), 0);

    mode = 2'b01;
    tick();
    for (int p = 0; p < 9; p++) begin
      step = 1;
      tick();
      chk("step_idx", 64'(idx), 64'((p + 1) % 8));
      chk("step_wrap", 64'(wrap), 64'(p == 7));
      step = 0;
      tick();
    end

    out_ready = 0;
    step = 1; tick();
    step = 0; tick();
    chk("pend_first", 64'(idx), 2);
    for (int p = 0; p < 3; p++) begin
      step = 1; tick();
      step = 0; tick();
    end
    chk("pend_held", 64'(idx), 2);
    out_ready = 1;
    tick();
    chk("pend_fire_idx", 64'(idx), 3);
    chk("pend_fire_valid", 64'(out_valid), 1);
    tick();
    chk("pend_done_valid", 64'(out_valid), 0);
    ticks(2);
    chk("pend_single", 64'(idx), 3);

    step = 1; tick();
    step = 0; out_ready = 0; tick();
    step = 1; out_ready = 1; tick();
    chk("edge_hs_idx", 64'(idx), 5);
    chk("edge_hs_valid", 64'(out_valid), 1);
    step = 0; tick();

    mode = 2'b10;
    tick();
    for (int k = 0; k < 3; k++) begin
      until_change(10, n);
      chk("auto_gap", 64'(n), 4);
    end
    chk("auto_idx0", 64'(idx), 0);
    chk("auto_wrap", 64'(wrap), 1);
    out_ready = 0;
    ticks(6);
    chk("auto_frozen", 64'(idx), 0);
    out_ready = 1;
    until_change(10, n);
    chk("auto_resume_gap", 64'(n), 4);
    chk("auto_resume_idx", 64'(idx), 1);

    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      if (idx == 3'd6 && out_valid) found = 1;
    end
    chk("reach_idx6", 64'(found), 1);
    rst = 1;
    tick();
    chk("midhs_rst_idx", 64'(idx), 0);
    chk("midhs_rst_A", 64'(A), 0);
    chk("midhs_rst_B", 64'(B), 0);
    chk("midhs_rst_valid", 64'(out_valid), 0);
    rst = 0;
    ticks(2);
    mode = 2'b11;
`ifdef OPSEQ_LFSR_EN
    until_change(12, n);
    chk("rnd_gap", 64'(n), 5);
    chk("rnd_A1", 64'(A), 64'hACE1_2345);
    chk("rnd_B1", 64'(B), 64'h2345_ACE1);
    chk("rnd_idx", 64'(idx), 7);
    ticks(4);
    chk("rnd_A2_differs", 64'(A != 32'hACE1_2345), 1);
`else
    ticks(12);
    chk("hold_idx", 64'(idx), 0);
    chk("hold_valid", 64'(out_valid), 0);
`endif

    for (int i = 0; i < 1500; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 15) == 0) mode = 2'($urandom_range(0, 3));
      sel = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 2) == 0) step = ~step;
      out_ready = ($urandom_range(0, 9) < 6);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
